// File: rtl/arcade_pkg.sv
// Shared arcade definitions: menu FSM states, button bit positions and board widths.
// Used by game_select_ctrl and game_best_table (optional feature macro GAME_SEL_BEST_SCORE_EN).
package arcade_pkg;

   typedef enum logic [1:0] {
      ST_MENU   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_PLAY   = 2'd2,
      ST_EXIT   = 2'd3
   } sel_state_t;

   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_SEL   = 4;

   localparam int GRID_BITS  = 64;
   localparam int LED_BITS   = 16;
   localparam int SCORE_BITS = 8;

endpackage

// File: rtl/game_best_table.sv
// Per-game best (lowest) score table. A record is captured on the rising edge of the
// active game's win flag while it is being played. Only built when GAME_SEL_BEST_SCORE_EN
// is defined. An entry of 0 means "no record yet".
module game_best_table
   import arcade_pkg::*;
#(
   parameter int NUM_GAMES = 4,
   parameter int SEL_W     = $clog2(NUM_GAMES)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             inPlay_i,
   input  logic                             stateChange_i,
   input  logic [SEL_W-1:0]                 sel_i,
   input  logic [NUM_GAMES-1:0]             gameCheckOk_i,
   input  logic [NUM_GAMES*SCORE_BITS-1:0]  gameScore_i,
   output logic [NUM_GAMES*SCORE_BITS-1:0]  best_o
);

   logic                  prevOk_q;
   logic [SCORE_BITS-1:0] best_q [NUM_GAMES];
   logic                  curOk;
   logic [SCORE_BITS-1:0] curScore;
   logic                  capture;

   assign curOk    = gameCheckOk_i[sel_i];
   assign curScore = gameScore_i[sel_i*SCORE_BITS +: SCORE_BITS];
   assign capture  = inPlay_i && curOk && !prevOk_q;

   // Flatten the table so the top can pick the selected entry with a part-select.
   always_comb begin
      best_o = '0;
      for (int g = 0; g < NUM_GAMES; g++) begin
         best_o[g*SCORE_BITS +: SCORE_BITS] = best_q[g];
      end
   end

   // Edge detector is cleared on every FSM transition so a flag left high by a previous
   // session cannot mask the first win of the next one; lower score replaces the record.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prevOk_q <= 1'b0;
         for (int g = 0; g < NUM_GAMES; g++) begin
            best_q[g] <= '0;
         end
      end else begin
         prevOk_q <= stateChange_i ? 1'b0 : curOk;
         if (capture && ((best_q[sel_i] == '0) || (curScore < best_q[sel_i]))) begin
            best_q[sel_i] <= curScore;
         end
      end
   end

endmodule

// File: rtl/game_select_ctrl.sv
// Arcade game selector: menu FSM, button routing to the active game, per-game reset
// control and a registered board output mux. Define GAME_SEL_BEST_SCORE_EN to add a
// per-game best-score table shown in the top grid row while in the menu.
module game_select_ctrl
   import arcade_pkg::*;
#(
   parameter int NUM_GAMES  = 4,
   parameter int RST_CYCLES = 4,
   localparam int SEL_W     = $clog2(NUM_GAMES)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [4:0]                       btn_pulse,
   input  logic [15:0]                      sw,
   output logic [4:0]                       game_btn_pulse,
   output logic [15:0]                      game_sw,
   output logic [NUM_GAMES-1:0]             game_rst,
   input  logic [NUM_GAMES*GRID_BITS-1:0]   game_grid,
   input  logic [NUM_GAMES*LED_BITS-1:0]    game_led,
   input  logic [NUM_GAMES-1:0]             game_check_ok,
   input  logic [NUM_GAMES*SCORE_BITS-1:0]  game_score,
   output logic [GRID_BITS-1:0]             grid,
   output logic [LED_BITS-1:0]              led,
   output logic                             check_ok,
   output logic [SCORE_BITS-1:0]            score,
   output logic [SEL_W-1:0]                 active_game,
   output logic                             in_menu
);

   sel_state_t             state_q, state_d;
   logic [SEL_W-1:0]       sel_q, sel_d;
   logic [7:0]             cnt_q, cnt_d;
   logic [NUM_GAMES-1:0]   gameRst_q, gameRst_d;
   logic                   inMenu_q;
   logic [GRID_BITS-1:0]   grid_q, grid_d;
   logic [LED_BITS-1:0]    led_q, led_d;
   logic                   checkOk_q, checkOk_d;
   logic [SCORE_BITS-1:0]  score_q, score_d;
   logic                   exitReq;
   logic [SCORE_BITS-1:0]  bestSel;

   assign exitReq = (state_q == ST_PLAY) && btn_pulse[BTN_SEL] && sw[15];

`ifdef GAME_SEL_BEST_SCORE_EN
   logic [NUM_GAMES*SCORE_BITS-1:0] bestFlat;

   game_best_table #(
      .NUM_GAMES (NUM_GAMES),
      .SEL_W     (SEL_W)
   ) u_best (
      .clk           (clk),
      .rst           (rst),
      .inPlay_i      (state_q == ST_PLAY),
      .stateChange_i (state_d != state_q),
      .sel_i         (sel_q),
      .gameCheckOk_i (game_check_ok),
      .gameScore_i   (game_score),
      .best_o        (bestFlat)
   );

   assign bestSel = bestFlat[sel_q*SCORE_BITS +: SCORE_BITS];
`else
   assign bestSel = '0;
`endif

   // Menu FSM: selection moves only in MENU, select press wins over arrows, LAUNCH
   // counts out the game reset, and only the qualified select press leaves PLAY.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_MENU: begin
            if (btn_pulse[BTN_SEL]) begin
               state_d = ST_LAUNCH;
               cnt_d   = '0;
            end else if (btn_pulse[BTN_RIGHT] && !btn_pulse[BTN_LEFT]) begin
               sel_d = (sel_q == SEL_W'(NUM_GAMES-1)) ? '0 : sel_q + 1'b1;
            end else if (btn_pulse[BTN_LEFT] && !btn_pulse[BTN_RIGHT]) begin
               sel_d = (sel_q == '0) ? SEL_W'(NUM_GAMES-1) : sel_q - 1'b1;
            end
         end
         ST_LAUNCH: begin
            if (cnt_q == 8'(RST_CYCLES-1)) begin
               state_d = ST_PLAY;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_PLAY: begin
            if (exitReq) begin
               state_d = ST_EXIT;
            end
         end
         ST_EXIT: begin
            state_d = ST_MENU;
         end
         default: begin
            state_d = ST_MENU;
         end
      endcase
   end

   // Game resets are computed from the next state and registered, so they change
   // cleanly on the clock edge with the state itself.
   always_comb begin
      gameRst_d = '1;
      if (state_d == ST_PLAY) begin
         gameRst_d[sel_d] = 1'b0;
      end
   end

   // Board mux: the active game's outputs in PLAY, otherwise the selection display.
   always_comb begin
      grid_d    = '0;
      led_d     = '0;
      checkOk_d = 1'b0;
      score_d   = '0;
      if (state_q == ST_PLAY) begin
         grid_d    = game_grid[sel_q*GRID_BITS +: GRID_BITS];
         led_d     = game_led[sel_q*LED_BITS +: LED_BITS];
         checkOk_d = game_check_ok[sel_q];
         score_d   = game_score[sel_q*SCORE_BITS +: SCORE_BITS];
      end else begin
         grid_d[7:0]        = 8'b1 << sel_q;
         grid_d[63:56]      = bestSel;
         led_d[15]          = 1'b1;
         led_d[SEL_W-1:0]   = sel_q;
      end
   end

   // Buttons reach the game in the same cycle, minus the press that ends the session.
   always_comb begin
      game_btn_pulse = '0;
      if (state_q == ST_PLAY) begin
         game_btn_pulse = btn_pulse;
         if (exitReq) begin
            game_btn_pulse[BTN_SEL] = 1'b0;
         end
      end
   end

   // All controller state and board outputs, cleared asynchronously to the menu view.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_MENU;
         sel_q     <= '0;
         cnt_q     <= '0;
         gameRst_q <= '1;
         inMenu_q  <= 1'b1;
         grid_q    <= 64'h1;
         led_q     <= 16'h8000;
         checkOk_q <= 1'b0;
         score_q   <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         gameRst_q <= gameRst_d;
         inMenu_q  <= (state_d == ST_MENU);
         grid_q    <= grid_d;
         led_q     <= led_d;
         checkOk_q <= checkOk_d;
         score_q   <= score_d;
      end
   end

   assign game_sw     = {1'b0, sw[14:0]};
   assign game_rst    = gameRst_q;
   assign in_menu     = inMenu_q;
   assign active_game = sel_q;
   assign grid        = grid_q;
   assign led         = led_q;
   assign check_ok    = checkOk_q;
   assign score       = score_q;

endmodule

// File: tb/tb_game_select_ctrl.sv
// Directed bench for game_select_ctrl with four games and a four-cycle launch reset.
// Best-score expectations follow GAME_SEL_BEST_SCORE_EN when it is defined.
module tb_game_select_ctrl;

   localparam logic [4:0] B_LEFT  = 5'b00100;
   localparam logic [4:0] B_RIGHT = 5'b01000;
   localparam logic [4:0] B_SEL   = 5'b10000;

   localparam logic [63:0] G0 = 64'h1111_0000_0000_0011;
   localparam logic [63:0] G1 = 64'h2222_0000_0000_0022;
   localparam logic [63:0] G2 = 64'h3333_0000_0000_0033;
   localparam logic [63:0] G3 = 64'h4444_0000_0000_0044;

   logic         clk;
   logic         rst;
   logic [4:0]   btnPulse;
   logic [15:0]  sw;
   logic [4:0]   gameBtnPulse;
   logic [15:0]  gameSw;
   logic [3:0]   gameRst;
   logic [255:0] gameGrid;
   logic [63:0]  gameLed;
   logic [3:0]   gameOk;
   logic [31:0]  gameScore;
   logic [7:0]   score1;
   logic [63:0]  grid;
   logic [15:0]  led;
   logic         checkOk;
   logic [7:0]   score;
   logic [1:0]   activeGame;
   logic         inMenu;

   int checkCount = 0;
   int passCount  = 0;

   assign gameGrid  = {G3, G2, G1, G0};
   assign gameLed   = {16'h0A04, 16'h0A03, 16'h0A02, 16'h0A01};
   assign gameScore = {8'd40, 8'd30, score1, 8'd10};

   game_select_ctrl #(
      .NUM_GAMES  (4),
      .RST_CYCLES (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .btn_pulse      (btnPulse),
      .sw             (sw),
      .game_btn_pulse (gameBtnPulse),
      .game_sw        (gameSw),
      .game_rst       (gameRst),
      .game_grid      (gameGrid),
      .game_led       (gameLed),
      .game_check_ok  (gameOk),
      .game_score     (gameScore),
      .grid           (grid),
      .led            (led),
      .check_ok       (checkOk),
      .score          (score),
      .active_game    (activeGame),
      .in_menu        (inMenu)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      if (obs === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 'h%0h, want 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [4:0] b);
      btnPulse = b;
      tick();
      btnPulse = '0;
   endtask

   function automatic logic [63:0] menuGrid(input logic [7:0] best, input logic [7:0] oneHot);
      return {best, 48'h0, oneHot};
   endfunction

   // From MENU: select, then wait out the four LAUNCH cycles.
   task automatic enterPlay();
      applyStimulus(B_SEL);
      repeat (4) tick();
   endtask

   // One win of game 1 with the given score, flag dropped afterwards.
   task automatic winGame(input logic [7:0] s);
      score1    = s;
      gameOk[1] = 1'b1;
      tick();
      gameOk[1] = 1'b0;
      tick();
   endtask

   // Qualified exit, through EXIT, back into MENU.
   task automatic exitPlay();
      sw       = 16'h8000;
      btnPulse = B_SEL;
      tick();
      btnPulse = '0;
      sw       = '0;
      checkOutput("exit_rst", 64'(gameRst), 64'hF);
      tick();
      checkOutput("exit_menu", 64'(inMenu), 64'h1);
   endtask

   initial begin
      logic [7:0] bestA;
      logic [7:0] bestB;
      logic [7:0] bestC;
`ifdef GAME_SEL_BEST_SCORE_EN
      bestA = 8'd12;
      bestB = 8'd12;
      bestC = 8'd9;
`else
      bestA = 8'd0;
      bestB = 8'd0;
      bestC = 8'd0;
`endif
      rst      = 1'b1;
      btnPulse = '0;
      sw       = '0;
      gameOk   = '0;
      score1   = 8'd12;
      repeat (2) tick();

      checkOutput("rst_grid", grid, 64'h1);
      checkOutput("rst_led", 64'(led), 64'h8000);
      checkOutput("rst_menu", 64'(inMenu), 64'h1);
      checkOutput("rst_sel", 64'(activeGame), 64'h0);
      checkOutput("rst_game_rst", 64'(gameRst), 64'hF);
      checkOutput("rst_score", 64'(score), 64'h0);
      checkOutput("rst_ok", 64'(checkOk), 64'h0);
      rst = 1'b0;
      tick();

      // Left twice wraps 0 -> 3 -> 2; display trails selection by one cycle.
      applyStimulus(B_LEFT);
      checkOutput("left1_sel", 64'(activeGame), 64'h3);
      applyStimulus(B_LEFT);
      checkOutput("left2_sel", 64'(activeGame), 64'h2);
      checkOutput("left2_grid", grid, 64'h08);
      tick();
      checkOutput("left2_grid_b", grid, 64'h04);
      checkOutput("left2_led", 64'(led), 64'h8002);

      applyStimulus(B_RIGHT);
      applyStimulus(B_LEFT | B_RIGHT);
      checkOutput("both_arrows", 64'(activeGame), 64'h3);
      applyStimulus(B_RIGHT);
      checkOutput("right_wrap", 64'(activeGame), 64'h0);
      applyStimulus(B_RIGHT);
      tick();
      checkOutput("sel1_led", 64'(led), 64'h8001);

      // Select with both arrows: launch game 1 without moving the selection.
      applyStimulus(B_SEL | B_LEFT | B_RIGHT);
      checkOutput("launch_sel", 64'(activeGame), 64'h1);
      checkOutput("launch_menu", 64'(inMenu), 64'h0);
      checkOutput("launch_rst1", 64'(gameRst), 64'hF);
      btnPulse = B_RIGHT;
      #1;
      checkOutput("launch_nofwd", 64'(gameBtnPulse), 64'h0);
      tick();
      btnPulse = '0;
      checkOutput("launch_rst2", 64'(gameRst), 64'hF);
      tick();
      checkOutput("launch_rst3", 64'(gameRst), 64'hF);
      tick();
      checkOutput("launch_rst4", 64'(gameRst), 64'hF);
      checkOutput("launch_sel_hold", 64'(activeGame), 64'h1);
      tick();
      checkOutput("play_rst", 64'(gameRst), 64'hD);
      checkOutput("play_menu", 64'(inMenu), 64'h0);
      checkOutput("play_grid_lag", grid, 64'h2);
      tick();
      checkOutput("play_grid", grid, G1);
      checkOutput("play_led", 64'(led), 64'h0A02);
      checkOutput("play_score", 64'(score), 64'd12);

      // Switch pass-through and button forwarding in PLAY.
      sw = 16'h8ABC;
      #1;
      checkOutput("game_sw", 64'(gameSw), 64'h0ABC);
      sw       = '0;
      btnPulse = B_SEL;
      #1;
      checkOutput("fwd_sel", 64'(gameBtnPulse), 64'h10);
      tick();
      btnPulse = 5'b01111;
      #1;
      checkOutput("fwd_arrows", 64'(gameBtnPulse), 64'h0F);
      checkOutput("stay_play", 64'(gameRst), 64'hD);
      tick();
      btnPulse = '0;

      // Three sessions of game 1: scores 12, 15, then 9 with the exit press.
      score1    = 8'd12;
      gameOk[1] = 1'b1;
      tick();
      checkOutput("win_ok", 64'(checkOk), 64'h1);
      gameOk[1] = 1'b0;
      tick();
      exitPlay();
      checkOutput("best_12", grid, menuGrid(bestA, 8'h02));

      enterPlay();
      winGame(8'd15);
      exitPlay();
      checkOutput("best_keep", grid, menuGrid(bestB, 8'h02));

      enterPlay();
      score1    = 8'd9;
      gameOk[1] = 1'b1;
      sw        = 16'h8000;
      btnPulse  = B_SEL;
      #1;
      checkOutput("exit_nofwd", 64'(gameBtnPulse), 64'h0);
      tick();
      btnPulse  = '0;
      gameOk[1] = 1'b0;
      sw        = '0;
      checkOutput("exit3_menu", 64'(inMenu), 64'h0);
      checkOutput("exit3_rst", 64'(gameRst), 64'hF);
      tick();
      checkOutput("best_9", grid, menuGrid(bestC, 8'h02));
      checkOutput("exit3_led", 64'(led), 64'h8001);

      // Asynchronous reset in the second LAUNCH cycle.
      applyStimulus(B_SEL);
      tick();
      rst = 1'b1;
      #1;
      checkOutput("arst_menu", 64'(inMenu), 64'h1);
      checkOutput("arst_sel", 64'(activeGame), 64'h0);
      checkOutput("arst_rst", 64'(gameRst), 64'hF);
      checkOutput("arst_grid", grid, 64'h1);
      tick();
      rst = 1'b0;
      applyStimulus(B_RIGHT);
      tick();
      checkOutput("arst_best_clr", grid, 64'h2);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/game_select_ctrl.md
# game_select_ctrl

Top-level arcade controller that shares the single button/switch input set, the 8x8 LED grid, the LED bank and the score display between `NUM_GAMES` game cores. It runs a menu state machine, routes button pulses only to the active game, and holds every inactive game in reset. It registers the active game's outputs onto the board. It sits between the button debouncer/pulse generator and the game cores such as the maze game.

## Interface
- `NUM_GAMES`, 4: number of attached game cores, 2..8; `SEL_W = $clog2(NUM_GAMES)`.
- `RST_CYCLES`, 4: cycles the selected game's reset is held in LAUNCH, 1..255.
- `clk  in  1`: system clock.
- `rst  in  1`: reset, asynchronous, active-high.
- `btn_pulse  in  5`: single-cycle button pulses. [0] up, [1] down, [2] left, [3] right, [4] select.
- `sw  in  16`: board switches. `sw[15]` is the menu-exit qualifier.
- `game_btn_pulse  out  5`: button pulses forwarded to the active game.
- `game_sw  out  16`: `sw` with bit 15 forced to 0.
- `game_rst  out  NUM_GAMES`: per-game synchronous reset, active-high.
- `game_grid  in  NUM_GAMES*64`: grid from game g at `[g*64 +: 64]`.
- `game_led  in  NUM_GAMES*16`: LED bank from each game.
- `game_check_ok  in  NUM_GAMES`: goal/win flag from each game.
- `game_score  in  NUM_GAMES*8`: score from each game.
- `grid  out  64`, `led  out  16`, `check_ok  out  1`, `score  out  8`: registered board outputs.
- `active_game  out  SEL_W`: current selection index.
- `in_menu  out  1`: high in MENU state.

## Operation
- States are MENU, LAUNCH, PLAY and EXIT.
- **MENU**
  - `btn_pulse[3]` increments `sel` and `btn_pulse[2]` decrements it.
  - Wrap-around: `NUM_GAMES-1` goes to 0, and 0 goes to `NUM_GAMES-1`.
  - If [2] and [3] arrive in the same cycle, `sel` is unchanged.
  - `btn_pulse[4]` goes to LAUNCH. Select has priority: if [4] arrives with [2] or [3], `sel` is not changed that cycle.
  - `btn_pulse[0]` and `btn_pulse[1]` are ignored.
- **LAUNCH**
  - `game_rst[sel]` is held high for exactly `RST_CYCLES` cycles, then the state goes to PLAY.
  - Buttons are ignored.
- **PLAY**
  - `game_rst[sel]` is 0.
  - `game_btn_pulse = btn_pulse`, except for the exit pulse.
  - `btn_pulse[4]` with `sw[15]=1` goes to EXIT, and that pulse is not forwarded.
  - `btn_pulse[4]` with `sw[15]=0` is forwarded normally.
- **EXIT**
  - Lasts one cycle, with `game_rst[sel]` high. Then the state goes to MENU.
- In every state, `game_rst[g]` is 1 for all `g != sel`.
- `game_btn_pulse` is 0 outside PLAY.
- Output mux in PLAY: `grid`, `led`, `check_ok` and `score` are taken from the slices for game `sel`.
- Menu display (MENU, LAUNCH, EXIT):
  - `grid[7:0]` is one-hot of `sel`; all other grid bits are 0, unless the best-score feature is enabled (see Configuration).
  - `led[15]=1`, `led[SEL_W-1:0]=sel`, all other LED bits 0.
  - `check_ok=0`, `score=0`.

## Timing
- Reset values:
  - State MENU, `sel=0`, `game_rst` all ones, `game_btn_pulse=0`.
  - `grid=64'h1`, `led=16'h8000`, `check_ok=0`, `score=0`, `in_menu=1`, `active_game=0`.
- `grid`, `led`, `check_ok` and `score` are registered: one cycle of latency from the game inputs or state change to the board outputs.
- `game_btn_pulse` and `game_sw` are combinational: zero latency, so a pulse reaches the game core in the same cycle.
- `game_rst` and `in_menu` are decoded from registered state and are glitch-free.
- Select pulse at cycle t (in MENU): LAUNCH is entered at t+1. `game_rst[sel]` is high for cycles t+1 .. t+RST_CYCLES. PLAY is entered at t+RST_CYCLES+1.
- An asynchronous `rst` during any state, including mid-LAUNCH, immediately returns all registers to their reset values.

## Configuration
- Macro `GAME_SEL_BEST_SCORE_EN`.
- When defined:
  - A per-game best-score table of 8-bit entries, reset to 0 (0 means no record).
  - Capture condition: rising edge of `game_check_ok[sel]` while in PLAY. Edge detection uses a registered copy that is cleared on every state change.
  - Update rule: the entry is written if it is 0 or `game_score[sel]` is less than the entry (lower is better).
  - A capture in the same cycle as the exit pulse still updates the table.
  - Menu display shows `grid[63:56] = best[sel]`.
- When undefined: the table is absent and `grid[63:56]=0` in the menu. All other behaviour is identical.

## Structure
- Shared package `arcade_pkg` holds:
  - The state enum `sel_state_t`.
  - Button index constants `BTN_UP`, `BTN_DOWN`, `BTN_LEFT`, `BTN_RIGHT`, `BTN_SEL` (0..4).
  - `GRID_BITS=64`, `LED_BITS=16`, `SCORE_BITS=8`.
- One sub-module, `game_best_table`, instantiated only under `GAME_SEL_BEST_SCORE_EN`. It contains the edge detector, the compare, and `NUM_GAMES` score registers.

## Test plan
- Reset, then two `btn_pulse[2]` with `NUM_GAMES=4`: `sel` goes 3 then 2, `grid[7:0]` goes 8'h08 then 8'h04, `led` reads 16'h8002.
- Select at cycle t: `game_rst[sel]` high for t+1..t+4. PLAY at t+5, `in_menu=0`, and `grid` equals `game_grid` slice `sel` one cycle later.
- In PLAY, `btn_pulse[4]` with `sw[15]=0`: forwarded, state stays PLAY. With `sw[15]=1`: not forwarded, one EXIT cycle, then MENU with `game_rst` all ones.
- `btn_pulse[2]`, `btn_pulse[3]` and `btn_pulse[4]` in the same MENU cycle: `sel` unchanged, LAUNCH entered for the original `sel`.
- With the macro defined: game 1 wins with score 12 (entry becomes 12), then a second win with 15 (entry stays 12), then a win with 9 (entry becomes 9). Menu `grid[63:56]=8'd9`.
- Assert `rst` at the second LAUNCH cycle: next edge shows MENU, `sel=0`, `game_rst=4'hF`, `grid=64'h1`, and the best table is cleared.
